multiplication_asmd_param: RTL and testbench

Parametrised sequential integer multiplier, the next generation of the shift-add ASMD multiplier used behind the CPU custom-instruction port. It retires STEP multiplier bits per iteration and terminates early once the remaining multiplier bits are zero. It exposes a busy/ready handshake and, when compiled in, signed operation. It sits between the custom-instruction decoder and the register write-back path.

---
 rtl/mul_asmd_pkg.sv | 22 ++
 rtl/mul_asmd_param_pp_step.sv | 22 ++
 rtl/multiplication_asmd_param.sv | 118 +++++++++++
 tb/tb_multiplication_asmd_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_asmd_pkg.sv
// Shared state encoding and parameter helpers for the parametrised shift-add multiplier.
// Signed operation is a build option selected with MUL_SIGNED_EN.
package mul_asmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit s set means STEP=s is a supported number of multiplier bits per iteration.
  localparam int unsigned LEGAL_STEP_MASK = 32'h0000_0016;

  function automatic bit stepIsLegal(input int step);
    return (step > 0) && (step < 32) && (((LEGAL_STEP_MASK >> step) & 32'd1) != 32'd0);
  endfunction

  function automatic int worstLatency(input int n, input int step);
    return n / step + 1;
  endfunction

endpackage

// File: rtl/mul_asmd_param_pp_step.sv
// Combinational partial-product stage: adds STEP shifted copies of the multiplicand to the accumulator.
module mul_pp_step #(
  parameter int N    = 16,
  parameter int STEP = 1
) (
  input  logic [2*N-1:0]  acc_i,
  input  logic [STEP-1:0] aBits_i,
  input  logic [2*N-1:0]  b_i,
  output logic [2*N-1:0]  accNext_o
);

  logic [2*N-1:0] sum;

  always_comb begin
    sum = acc_i;
    for (int i = 0; i < STEP; i++) begin
      if (aBits_i[i]) sum = sum + (b_i << i);
    end
    accNext_o = sum;
  end

endmodule

// File: rtl/multiplication_asmd_param.sv
// Shift-add multiplier retiring STEP multiplier bits per iteration with early termination.
// Define MUL_SIGNED_EN to add the signed_op port and two's-complement operation.
module multiplication_asmd_param
  import mul_asmd_pkg::*;
#(
  parameter int N    = 16,
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           start,
`ifdef MUL_SIGNED_EN
  input  logic           signed_op,
`endif
  input  logic [N-1:0]   dataA,
  input  logic [N-1:0]   dataB,
  output logic [2*N-1:0] res,
  output logic           rdy,
  output logic           busy
);

  if (!stepIsLegal(STEP) || (N % STEP) != 0 || N < 4 || N > 32) begin : gBadParams
    $error("multiplication_asmd_param: illegal N/STEP combination");
  end

  state_t         state_q;
  logic [N-1:0]   aReg_q;
  logic [2*N-1:0] bReg_q;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] res_q;
  logic           rdy_q;
  logic           busy_q;

  logic [N-1:0]   aLoad_d;
  logic [N-1:0]   bMag_d;
  logic [N-1:0]   aShift_d;
  logic [2*N-1:0] accNext_d;
  logic [2*N-1:0] resNext_d;

`ifdef MUL_SIGNED_EN
  logic neg_q;
  logic negLoad_d;

  // Work on magnitudes; -2^(N-1) maps onto 2^(N-1), which still fits unsigned in N bits.
  always_comb begin
    aLoad_d   = (signed_op && dataA[N-1]) ? -dataA : dataA;
    bMag_d    = (signed_op && dataB[N-1]) ? -dataB : dataB;
    negLoad_d = signed_op & (dataA[N-1] ^ dataB[N-1]);
    resNext_d = neg_q ? -acc_q : acc_q;
  end
`else
  always_comb begin
    aLoad_d   = dataA;
    bMag_d    = dataB;
    resNext_d = acc_q;
  end
`endif

  assign aShift_d = aReg_q >> STEP;

  mul_pp_step #(.N(N), .STEP(STEP)) u_pp_step (
    .acc_i     (acc_q),
    .aBits_i   (aReg_q[STEP-1:0]),
    .b_i       (bReg_q),
    .accNext_o (accNext_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      aReg_q  <= '0;
      bReg_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b0;
          if (start) begin
            aReg_q  <= aLoad_d;
            bReg_q  <= {{N{1'b0}}, bMag_d};
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
`ifdef MUL_SIGNED_EN
            neg_q   <= negLoad_d;
`endif
          end
        end
        // Stop as soon as no multiplier bits remain; at least one pass always runs.
        CALC: begin
          acc_q  <= accNext_d;
          aReg_q <= aShift_d;
          bReg_q <= bReg_q << STEP;
          if (aShift_d == '0) state_q <= DONE;
        end
        DONE: begin
          res_q   <= resNext_d;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res  = res_q;
  assign rdy  = rdy_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_multiplication_asmd_param.sv
// Bench for multiplication_asmd_param: STEP=1, 2 and 4 instances share stimulus and are checked
// against a plain-arithmetic model; signed vectors are added when MUL_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_multiplication_asmd_param;
  import mul_asmd_pkg::*;

  localparam int N  = 16;
  localparam int NI = 3;
  localparam int STEPS [NI] = '{1, 2, 4};

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    bit             sgn;
    logic [2*N-1:0] expRes;
    int             lat1;
    int             lat2;
    int             lat4;
  } vector_t;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic start;
`ifdef MUL_SIGNED_EN
  logic signedOp;
`endif
  logic [N-1:0] dataA;
  logic [N-1:0] dataB;
  logic [NI-1:0][2*N-1:0] resV;
  logic [NI-1:0] rdyV;
  logic [NI-1:0] busyV;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multiplication_asmd_param #(.N(N), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
`ifdef MUL_SIGNED_EN
    .signed_op(signedOp),
`endif
    .dataA(dataA), .dataB(dataB), .res(resV[0]), .rdy(rdyV[0]), .busy(busyV[0]));

  multiplication_asmd_param #(.N(N), .STEP(2)) u2 (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
`ifdef MUL_SIGNED_EN
    .signed_op(signedOp),
`endif
    .dataA(dataA), .dataB(dataB), .res(resV[1]), .rdy(rdyV[1]), .busy(busyV[1]));

  multiplication_asmd_param #(.N(N), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
`ifdef MUL_SIGNED_EN
    .signed_op(signedOp),
`endif
    .dataA(dataA), .dataB(dataB), .res(resV[2]), .rdy(rdyV[2]), .busy(busyV[2]));

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [2*N-1:0] modelProduct(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn);
    longint sa, sb, p;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[2*N-1:0];
  endfunction

  // Enabled cycles from acceptance to rdy: one per STEP-bit group of |a| (at least one), plus DONE.
  function automatic int modelLatency(input logic [N-1:0] a, input bit sgn, input int step);
    logic [N-1:0] mag;
    int bits, k;
    mag  = (sgn && a[N-1]) ? -a : a;
    bits = 0;
    for (int i = 0; i < N; i++) if (mag[i]) bits = i + 1;
    k = (bits + step - 1) / step;
    if (k < 1) k = 1;
    return k + 1;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn,
                               input logic [2*N-1:0] expRes, input int l1, input int l2, input int l4,
                               input string tag);
    int expLat [NI];
    int lat [NI];
    int busyCnt [NI];
    int cMax;
    string name;
    name = sgn ? {tag, "/s"} : tag;
    expLat[0] = l1;
    expLat[1] = l2;
    expLat[2] = l4;
    for (int i = 0; i < NI; i++) begin
      lat[i] = 0;
      busyCnt[i] = 0;
    end
    cMax = worstLatency(N, 1) + 2;
    dataA = a;
    dataB = b;
`ifdef MUL_SIGNED_EN
    signedOp = sgn;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    // Start stays high over the first CALC edge and operands change: both must be ignored.
    dataA = N'($urandom);
    dataB = N'($urandom);
    for (int i = 0; i < NI; i++) if (busyV[i]) busyCnt[i]++;
    for (int c = 1; c <= cMax; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] == 0) begin
          if (busyV[i]) busyCnt[i]++;
          if (rdyV[i]) begin
            lat[i] = c;
            checkOutput($sformatf("%s res step%0d", name, STEPS[i]), 64'(resV[i]), 64'(expRes));
          end
        end else if (c == lat[i] + 1) begin
          checkOutput($sformatf("%s rdy pulse step%0d", name, STEPS[i]), 64'(rdyV[i]), 64'd0);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("%s latency step%0d", name, STEPS[i]), 64'(lat[i]), 64'(expLat[i]));
      checkOutput($sformatf("%s busy cycles step%0d", name, STEPS[i]), 64'(busyCnt[i]), 64'(expLat[i]));
    end
  endtask

  vector_t vectors [$];

  initial begin
    int lat [NI];
    int rdyHigh [NI];
    logic [N-1:0] ra, rb;
    bit rs;

    vectors.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17, 9, 5});
    vectors.push_back('{16'h0003, 16'h1234, 1'b0, 32'h0000369C, 3, 2, 2});
    vectors.push_back('{16'h0000, 16'hABCD, 1'b0, 32'h00000000, 2, 2, 2});
    vectors.push_back('{16'h0001, 16'h0001, 1'b0, 32'h00000001, 2, 2, 2});
    vectors.push_back('{16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 9, 5, 3});
    vectors.push_back('{16'h8000, 16'h0002, 1'b0, 32'h00010000, 17, 9, 5});
`ifdef MUL_SIGNED_EN
    vectors.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000, 17, 9, 5});
    vectors.push_back('{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 2, 2, 2});
    signedOp = 1'b0;
`endif

    // Reset with ena low: reset must still win.
    rst = 1'b0; ena = 1'b0; start = 1'b0; dataA = '0; dataB = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset res step%0d", STEPS[i]), 64'(resV[i]), 64'd0);
      checkOutput($sformatf("reset rdy step%0d", STEPS[i]), 64'(rdyV[i]), 64'd0);
      checkOutput($sformatf("reset busy step%0d", STEPS[i]), 64'(busyV[i]), 64'd0);
    end
    rst = 1'b1; ena = 1'b1;
    @(posedge clk); #1;

    foreach (vectors[v])
      applyStimulus(vectors[v].a, vectors[v].b, vectors[v].sgn, vectors[v].expRes,
                    vectors[v].lat1, vectors[v].lat2, vectors[v].lat4, $sformatf("vec%0d", v));

    for (int r = 0; r < 8; r++) begin
      ra = N'($urandom) >> $urandom_range(0, N - 1);
      rb = N'($urandom);
      rs = 1'b0;
`ifdef MUL_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`endif
      applyStimulus(ra, rb, rs, modelProduct(ra, rb, rs), modelLatency(ra, rs, 1),
                    modelLatency(ra, rs, 2), modelLatency(ra, rs, 4), $sformatf("rand%0d", r));
    end

    // Reset during the third CALC iteration with start held high: abort, no rdy, res cleared.
    dataA = 16'hFFFF; dataB = 16'h1234; start = 1'b1;
`ifdef MUL_SIGNED_EN
    signedOp = 1'b0;
`endif
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("abort res step%0d", STEPS[i]), 64'(resV[i]), 64'd0);
      checkOutput($sformatf("abort rdy step%0d", STEPS[i]), 64'(rdyV[i]), 64'd0);
      checkOutput($sformatf("abort busy step%0d", STEPS[i]), 64'(busyV[i]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      checkOutput($sformatf("abort held rdy step%0d", STEPS[i]), 64'(rdyV[i]), 64'd0);
    rst = 1'b1;
    applyStimulus(16'h0005, 16'h0007, 1'b0, 32'h00000023, 4, 3, 2, "after abort");

    // ena toggling every cycle: latency doubles in raw clocks and rdy survives the stalled cycle.
    dataA = 16'h00FF; dataB = 16'h0101; start = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ena = 1'b0;
    for (int i = 0; i < NI; i++) begin
      lat[i] = 0;
      rdyHigh[i] = 0;
    end
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      ena = (c % 2 == 1);
      for (int i = 0; i < NI; i++) begin
        if (rdyV[i]) begin
          rdyHigh[i]++;
          if (lat[i] == 0) begin
            lat[i] = c;
            checkOutput($sformatf("stall res step%0d", STEPS[i]), 64'(resV[i]), 64'h0000FFFF);
          end
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("stall latency step%0d", STEPS[i]), 64'(lat[i]),
                  64'(2 * modelLatency(16'h00FF, 1'b0, STEPS[i])));
      checkOutput($sformatf("stall rdy width step%0d", STEPS[i]), 64'(rdyHigh[i]), 64'd2);
    end
    ena = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
